// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: datapath widths, funct3 encodings and the ALU
// control codes the control unit selects for branch comparisons.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    // ALU operations chosen by the control unit for branch compares
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1101;

endpackage

// File: rtl/ex_mem_reg_if.sv
// EX/MEM boundary bundle: hazard controls, EX-side inputs and MEM-side outputs.
import riscv_pkg::*;

interface ex_mem_reg_if;

    // Hazard unit controls
    logic              stall;
    logic              flush;

    // EX stage
    logic              ex_valid;
    logic [XLEN-1:0]   alu_result;
    logic              zero_flag;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   branch_target;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              branch;
    logic              jump;
    logic [2:0]        funct3;

    // MEM stage
    logic              mem_valid;
    logic [XLEN-1:0]   mem_alu_result;
    logic [XLEN-1:0]   mem_store_data;
    logic [3:0]        mem_byte_en;
    logic [REG_AW-1:0] mem_rd;
    logic [2:0]        mem_funct3;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              mem_mem_to_reg;
    logic              branch_taken;
    logic [XLEN-1:0]   mem_branch_target;
    logic              misaligned;

    // Upstream side: drives EX inputs and controls, observes MEM outputs
    modport master (
        output stall, flush, ex_valid, alu_result, zero_flag, rs2_data,
               branch_target, rd, reg_write, mem_read, mem_write, mem_to_reg,
               branch, jump, funct3,
        input  mem_valid, mem_alu_result, mem_store_data, mem_byte_en, mem_rd,
               mem_funct3, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_mem_to_reg, branch_taken, mem_branch_target, misaligned
    );

    // Pipeline register side
    modport slave (
        input  stall, flush, ex_valid, alu_result, zero_flag, rs2_data,
               branch_target, rd, reg_write, mem_read, mem_write, mem_to_reg,
               branch, jump, funct3,
        output mem_valid, mem_alu_result, mem_store_data, mem_byte_en, mem_rd,
               mem_funct3, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_mem_to_reg, branch_taken, mem_branch_target, misaligned
    );

endinterface

// File: rtl/ex_mem_reg_store_align.sv
// Store lane alignment, byte-enable generation and misalignment detection.
module store_align
    import riscv_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic            i_mem_write,
    input  logic            i_mem_read,
    output logic [XLEN-1:0] o_store_data,
    output logic [3:0]      o_byte_en,
    output logic            o_misaligned
);

    logic [XLEN-1:0] w_sb_data;
    logic [XLEN-1:0] w_sh_data;

    // Byte and halfword replication across the four lanes
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_sb_data[8*gi +: 8] = i_rs2_data[7:0];
            assign w_sh_data[8*gi +: 8] = i_rs2_data[8*(gi%2) +: 8];
        end
    endgenerate

    // Misalignment check, lane select and enables; unknown store widths act as SW
    always_comb begin
        o_misaligned = (i_mem_read | i_mem_write) &
                       (((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                        ((i_funct3[1:0] == 2'b10) & (i_addr != 2'b00)));
        case (i_funct3)
            F3_SB: begin
                o_store_data = w_sb_data;
                o_byte_en    = 4'b0001 << i_addr;
            end
            F3_SH: begin
                o_store_data = w_sh_data;
                o_byte_en    = 4'b0011 << {i_addr[1], 1'b0};
            end
            default: begin
                o_store_data = i_rs2_data;
                o_byte_en    = 4'b1111;
            end
        endcase
        if (!i_mem_write || o_misaligned) begin
            o_byte_en = 4'b0000;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures ALU result and control, resolves
// branches and aligns store data. Every output is driven from a flop.
module ex_mem_reg
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    ex_mem_reg_if.slave  bus
);

    logic              w_cond;
    logic              w_taken;
    logic [XLEN-1:0]   w_store_data;
    logic [3:0]        w_byte_en;
    logic              w_misaligned;

    logic              r_valid;
    logic [XLEN-1:0]   r_alu_result;
    logic [XLEN-1:0]   r_store_data;
    logic [3:0]        r_byte_en;
    logic [REG_AW-1:0] r_rd;
    logic [2:0]        r_funct3;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_branch_taken;
    logic [XLEN-1:0]   r_branch_target;
    logic              r_misaligned;

    store_align u_store_align (
        .i_funct3     (bus.funct3),
        .i_addr       (bus.alu_result[1:0]),
        .i_rs2_data   (bus.rs2_data),
        .i_mem_write  (bus.mem_write),
        .i_mem_read   (bus.mem_read),
        .o_store_data (w_store_data),
        .o_byte_en    (w_byte_en),
        .o_misaligned (w_misaligned)
    );

    // Branch condition from ALU flags (SUB for EQ/NE, SLT/SLTU for the rest)
    always_comb begin
        case (bus.funct3)
            F3_BEQ:           w_cond = bus.zero_flag;
            F3_BNE:           w_cond = ~bus.zero_flag;
            F3_BLT, F3_BLTU:  w_cond = bus.alu_result[0];
            F3_BGE, F3_BGEU:  w_cond = ~bus.alu_result[0];
            default:          w_cond = 1'b0;
        endcase
        w_taken = bus.ex_valid & (bus.jump | (bus.branch & w_cond));
    end

    // Slot update: reset > stall (hold) > flush (bubble) > capture
    always_ff @(posedge clk) begin
        if (reset || (!bus.stall && bus.flush)) begin
            r_valid         <= 1'b0;
            r_alu_result    <= '0;
            r_store_data    <= '0;
            r_byte_en       <= 4'b0000;
            r_rd            <= '0;
            r_funct3        <= 3'b000;
            r_reg_write     <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_branch_taken  <= 1'b0;
            r_branch_target <= '0;
            r_misaligned    <= 1'b0;
        end else if (!bus.stall) begin
            r_valid         <= bus.ex_valid;
            r_alu_result    <= bus.alu_result;
            r_store_data    <= w_store_data;
            r_byte_en       <= bus.ex_valid ? w_byte_en : 4'b0000;
            r_rd            <= bus.rd;
            r_funct3        <= bus.funct3;
            r_reg_write     <= bus.ex_valid & bus.reg_write & ~w_misaligned;
            r_mem_read      <= bus.ex_valid & bus.mem_read  & ~w_misaligned;
            r_mem_write     <= bus.ex_valid & bus.mem_write & ~w_misaligned;
            r_mem_to_reg    <= bus.ex_valid & bus.mem_to_reg;
            r_branch_taken  <= w_taken;
            r_branch_target <= bus.branch_target;
            r_misaligned    <= bus.ex_valid & w_misaligned;
        end
    end

    assign bus.mem_valid         = r_valid;
    assign bus.mem_alu_result    = r_alu_result;
    assign bus.mem_store_data    = r_store_data;
    assign bus.mem_byte_en       = r_byte_en;
    assign bus.mem_rd            = r_rd;
    assign bus.mem_funct3        = r_funct3;
    assign bus.mem_reg_write     = r_reg_write;
    assign bus.mem_mem_read      = r_mem_read;
    assign bus.mem_mem_write     = r_mem_write;
    assign bus.mem_mem_to_reg    = r_mem_to_reg;
    assign bus.branch_taken      = r_branch_taken;
    assign bus.mem_branch_target = r_branch_target;
    assign bus.misaligned        = r_misaligned;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed testbench for ex_mem_reg with hand-computed expectations.
module tb_ex_mem_reg;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    ex_mem_reg_if bus ();

    ex_mem_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.ex_valid      = 1'b0;
        bus.alu_result    = 32'h0;
        bus.zero_flag     = 1'b0;
        bus.rs2_data      = 32'h0;
        bus.branch_target = 32'h0;
        bus.rd            = 5'd0;
        bus.reg_write     = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.branch        = 1'b0;
        bus.jump          = 1'b0;
        bus.funct3        = 3'b000;
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        idle_inputs();
        bus.ex_valid   = 1'b1;
        bus.mem_write  = 1'b1;
        bus.funct3     = f3;
        bus.alu_result = addr;
        bus.rs2_data   = data;
    endtask

    task automatic br(input logic [2:0] f3, input logic [31:0] alu, input logic zf, input logic jmp);
        idle_inputs();
        bus.ex_valid      = 1'b1;
        bus.branch        = ~jmp;
        bus.jump          = jmp;
        bus.funct3        = f3;
        bus.alu_result    = alu;
        bus.zero_flag     = zf;
        bus.branch_target = 32'h40;
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_valid"},  {31'b0, bus.mem_valid},      32'h0);
        chk({pfx, "_alu"},    bus.mem_alu_result,          32'h0);
        chk({pfx, "_sdata"},  bus.mem_store_data,          32'h0);
        chk({pfx, "_be"},     {28'b0, bus.mem_byte_en},    32'h0);
        chk({pfx, "_rd"},     {27'b0, bus.mem_rd},         32'h0);
        chk({pfx, "_f3"},     {29'b0, bus.mem_funct3},     32'h0);
        chk({pfx, "_rw"},     {31'b0, bus.mem_reg_write},  32'h0);
        chk({pfx, "_mr"},     {31'b0, bus.mem_mem_read},   32'h0);
        chk({pfx, "_mw"},     {31'b0, bus.mem_mem_write},  32'h0);
        chk({pfx, "_m2r"},    {31'b0, bus.mem_mem_to_reg}, 32'h0);
        chk({pfx, "_taken"},  {31'b0, bus.branch_taken},   32'h0);
        chk({pfx, "_tgt"},    bus.mem_branch_target,       32'h0);
        chk({pfx, "_mis"},    {31'b0, bus.misaligned},     32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // SW aligned
        store(3'b010, 32'h100, 32'hDEADBEEF);
        bus.rd = 5'd7;
        tick();
        $display("txn SW  addr=0x100 data=0xDEADBEEF");
        chk("sw_valid", {31'b0, bus.mem_valid},     32'h1);
        chk("sw_be",    {28'b0, bus.mem_byte_en},   32'hF);
        chk("sw_data",  bus.mem_store_data,         32'hDEADBEEF);
        chk("sw_mw",    {31'b0, bus.mem_mem_write}, 32'h1);
        chk("sw_alu",   bus.mem_alu_result,         32'h100);
        chk("sw_rd",    {27'b0, bus.mem_rd},        32'h7);
        chk("sw_mis",   {31'b0, bus.misaligned},    32'h0);

        // SB at byte 3 (back-to-back capture)
        store(3'b000, 32'h103, 32'h000000A5);
        tick();
        $display("txn SB  addr=0x103 data=0xA5");
        chk("sb_be",   {28'b0, bus.mem_byte_en}, 32'h8);
        chk("sb_data", bus.mem_store_data,       32'hA5A5A5A5);

        // SH upper halfword
        store(3'b001, 32'h102, 32'h1234BEEF);
        tick();
        $display("txn SH  addr=0x102 data=0x1234BEEF");
        chk("sh_be",   {28'b0, bus.mem_byte_en}, 32'hC);
        chk("sh_data", bus.mem_store_data,       32'hBEEFBEEF);

        // Branches
        br(3'b100, 32'h1, 1'b0, 1'b0);
        tick();
        $display("txn BLT alu=1");
        chk("blt_taken", {31'b0, bus.branch_taken}, 32'h1);
        chk("blt_tgt",   bus.mem_branch_target,     32'h40);
        chk("blt_be",    {28'b0, bus.mem_byte_en},  32'h0);

        br(3'b101, 32'h1, 1'b0, 1'b0);
        tick();
        $display("txn BGE alu=1");
        chk("bge_taken", {31'b0, bus.branch_taken}, 32'h0);

        br(3'b000, 32'h0, 1'b1, 1'b0);
        tick();
        $display("txn BEQ zero=1");
        chk("beq_taken", {31'b0, bus.branch_taken}, 32'h1);

        br(3'b001, 32'h0, 1'b1, 1'b0);
        tick();
        $display("txn BNE zero=1");
        chk("bne_taken", {31'b0, bus.branch_taken}, 32'h0);

        br(3'b111, 32'h0, 1'b0, 1'b0);
        tick();
        $display("txn BGEU alu=0");
        chk("bgeu_taken", {31'b0, bus.branch_taken}, 32'h1);

        br(3'b010, 32'h1, 1'b1, 1'b0);
        tick();
        $display("txn branch f3=010");
        chk("f3_010_taken", {31'b0, bus.branch_taken}, 32'h0);

        br(3'b010, 32'h0, 1'b0, 1'b1);
        tick();
        $display("txn JAL");
        chk("jal_taken", {31'b0, bus.branch_taken}, 32'h1);

        // Misaligned SH
        store(3'b001, 32'h101, 32'h0000BEEF);
        tick();
        $display("txn SH  addr=0x101 (misaligned)");
        chk("mis_sh_mis",   {31'b0, bus.misaligned},    32'h1);
        chk("mis_sh_mw",    {31'b0, bus.mem_mem_write}, 32'h0);
        chk("mis_sh_be",    {28'b0, bus.mem_byte_en},   32'h0);
        chk("mis_sh_valid", {31'b0, bus.mem_valid},     32'h1);

        // Misaligned LW
        idle_inputs();
        bus.ex_valid   = 1'b1;
        bus.mem_read   = 1'b1;
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.funct3     = 3'b010;
        bus.alu_result = 32'h102;
        tick();
        $display("txn LW  addr=0x102 (misaligned)");
        chk("mis_lw_mis", {31'b0, bus.misaligned},    32'h1);
        chk("mis_lw_mr",  {31'b0, bus.mem_mem_read},  32'h0);
        chk("mis_lw_rw",  {31'b0, bus.mem_reg_write}, 32'h0);

        // Aligned LH keeps controls
        bus.funct3 = 3'b001;
        tick();
        $display("txn LH  addr=0x102");
        chk("lh_mis", {31'b0, bus.misaligned},    32'h0);
        chk("lh_mr",  {31'b0, bus.mem_mem_read},  32'h1);
        chk("lh_rw",  {31'b0, bus.mem_reg_write}, 32'h1);
        chk("lh_be",  {28'b0, bus.mem_byte_en},   32'h0);

        // Stall holds through input changes and flush
        store(3'b010, 32'h200, 32'h11223344);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            bus.stall      = 1'b1;
            bus.flush      = (i != 1);
            bus.ex_valid   = 1'b1;
            bus.branch     = 1'b1;
            bus.zero_flag  = 1'b1;
            bus.funct3     = 3'b000;
            bus.alu_result = 32'h300 + i;
            bus.rs2_data   = 32'hCAFE0000 + i;
            tick();
            $display("txn stall cycle %0d", i);
            chk("stall_alu",   bus.mem_alu_result,         32'h200);
            chk("stall_data",  bus.mem_store_data,         32'h11223344);
            chk("stall_be",    {28'b0, bus.mem_byte_en},   32'hF);
            chk("stall_mw",    {31'b0, bus.mem_mem_write}, 32'h1);
            chk("stall_valid", {31'b0, bus.mem_valid},     32'h1);
            chk("stall_taken", {31'b0, bus.branch_taken},  32'h0);
        end

        // Flush after stall
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        tick();
        $display("txn flush");
        check_all_zero("flush");

        // Held taken branch, then reset during stall
        br(3'b000, 32'h0, 1'b1, 1'b0);
        bus.rd = 5'd3;
        tick();
        bus.stall = 1'b1;
        tick();
        $display("txn stalled taken branch");
        chk("held_taken", {31'b0, bus.branch_taken}, 32'h1);
        chk("held_tgt",   bus.mem_branch_target,     32'h40);
        reset = 1'b1;
        tick();
        $display("txn reset during stall");
        check_all_zero("rst_stall");
        reset = 1'b0;

        // Bubble capture
        idle_inputs();
        bus.ex_valid  = 1'b0;
        bus.reg_write = 1'b1;
        bus.mem_write = 1'b1;
        bus.jump      = 1'b1;
        tick();
        $display("txn bubble ex_valid=0");
        chk("bub_valid", {31'b0, bus.mem_valid},     32'h0);
        chk("bub_rw",    {31'b0, bus.mem_reg_write}, 32'h0);
        chk("bub_mw",    {31'b0, bus.mem_mem_write}, 32'h0);
        chk("bub_taken", {31'b0, bus.branch_taken},  32'h0);
        chk("bub_be",    {28'b0, bus.mem_byte_en},   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register of the RISC-V core; it sits directly downstream of the ALU. It captures the ALU result and EX-stage control for the MEM stage. It resolves conditional branches from the ALU flags and aligns store data with byte enables. It also flags misaligned accesses, and it supports stall and flush from the hazard unit.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register-index width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold current MEM contents
- flush  in  1  load a bubble instead of the EX instruction
- ex_valid  in  1  EX slot holds a real instruction
- alu_result  in  XLEN  ALU output (address, arithmetic result or SLT/SLTU bit)
- zero_flag  in  1  ALU zero flag
- rs2_data  in  XLEN  forwarded store operand
- branch_target  in  XLEN  precomputed PC target (branch/JAL/JALR)
- rd  in  REG_AW  destination register
- reg_write, mem_read, mem_write, mem_to_reg, branch, jump  in  1 each  decoded control
- funct3  in  3  instruction funct3
- mem_valid  out  1  MEM slot holds a real instruction
- mem_alu_result  out  XLEN  registered alu_result
- mem_store_data  out  XLEN  lane-replicated store data
- mem_byte_en  out  4  store byte enables
- mem_rd  out  REG_AW;  mem_funct3  out  3
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  out  1 each
- branch_taken  out  1  redirect request to fetch
- mem_branch_target  out  XLEN
- misaligned  out  1  misaligned load/store trapped in this slot

## Operation
- Update priority at each edge: reset > stall > flush > capture.
- reset: every output is 0.
- stall=1: every register holds; flush is ignored in the same cycle.
- flush=1 (stall=0): mem_valid, all control outputs, branch_taken, misaligned and mem_byte_en are 0. The data registers also load 0.
- capture: mem_valid <= ex_valid. Every control output is ANDed with ex_valid.
- Branch decision uses funct3 and requires the control unit to select SUB for BEQ/BNE, SLT for BLT/BGE and SLTU for BLTU/BGEU:
  - 000 gives zero_flag; 001 gives ~zero_flag.
  - 100 and 110 give alu_result[0]; 101 and 111 give ~alu_result[0].
  - 010 and 011 give 0.
- taken = ex_valid & (jump | (branch & cond)). It is registered into branch_taken.
- Store alignment uses a = alu_result[1:0]:
  - SB (000): data is rs2[7:0] ×4; byte_en = 0001 << a.
  - SH (001): data is rs2[15:0] ×2; byte_en = 0011 << (2·a[1]).
  - SW (010): data is rs2; byte_en = 1111.
  - mem_byte_en is 0000 whenever mem_write=0.
- Misaligned access is halfword (funct3[1:0]=01) with a[0]=1, or word (10) with a≠00. It applies when mem_read or mem_write is set.
- On a misaligned access: misaligned=1; mem_mem_read, mem_mem_write, mem_reg_write and mem_byte_en are forced to 0; mem_valid stays 1.
- Unaligned funct3 (011, 11x) on a store is treated as SW alignment. No error is raised.

## Timing
- Latency: 1 cycle. All outputs come straight from flops, with no combinational input-to-output path.
- branch_taken stays high for as long as the slot is held by stall. The front end treats a repeated redirect as idempotent.
- The hazard unit must assert flush on this block in the same cycle it sees branch_taken=1, which kills the wrong-path EX instruction.
- Reset during stall or flush still clears everything at the next edge.
- Back-to-back captures need no gap, so throughput is 1 instruction per cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - funct3 localparams (F3_BEQ…F3_BGEU, F3_SB/SH/SW)
  - ALU control codes (ALU_SUB=4'b0110, ALU_SLT=4'b1100, ALU_SLTU=4'b1101), shared with the ALU and control unit
  - XLEN and REG_AW defaults
- One combinational sub-module, `store_align`, takes funct3, addr[1:0], rs2_data and mem_write/mem_read. It produces store_data, byte_en and misaligned. The branch-condition logic stays inline.

## Test plan
- SW with alu_result=0x100, rs2=0xDEADBEEF, ex_valid=1 → next cycle: mem_valid=1, mem_byte_en=1111, mem_store_data=0xDEADBEEF, mem_mem_write=1.
- SB with alu_result=0x103, rs2=0x000000A5 → mem_byte_en=1000, mem_store_data=0xA5A5A5A5.
- Branches, all with branch_target=0x40:
  - BLT (funct3=100), alu_result=1 → branch_taken=1, mem_branch_target=0x40.
  - BGE with the same inputs → branch_taken=0.
  - BEQ with zero_flag=1 → branch_taken=1.
- SH with alu_result=0x101 → misaligned=1, mem_mem_write=0, mem_byte_en=0000, mem_valid=1.
- Stall and flush:
  - Capture a store, then hold stall=1 for 3 cycles while toggling inputs (including flush=1) → outputs unchanged.
  - Then stall=0, flush=1 → mem_valid=0 and all controls 0.
- Assert reset while stall=1 and a valid taken branch is held → next edge: every output 0.
- Capture with ex_valid=0 and reg_write=1 → mem_valid=0, mem_reg_write=0.
